// File: rtl/fetch_unit.sv
// Instruction fetch: FSM issues one imem request at a time into a prefetch buffer; redirect flushes.
// Latency: ack to inst_valid_o is one cycle, or zero when FETCH_UNIT_BYPASS_EN bypasses an empty buffer.
// Backpressure: inst_ready_i holds entries in the buffer, and no new request is issued while it is full.

// Generic prefetch FIFO. Latency: one cycle from push to head.
// Backpressure: a push into a full FIFO or a pop from an empty one is ignored. flush empties it.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_rdy,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign do_push  = push_vld && !flush && (count != FULL_CNT);
  assign do_pop   = pop_rdy && !flush && (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   imem_req_o,
  output logic [XLEN-1:0]        imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [31:0]            imem_data_i,
  output logic                   inst_valid_o,
  output logic [31:0]            inst_o,
  output logic [XLEN-1:0]        inst_pc_o,
  input  logic                   inst_ready_i,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  state_t          state;
  logic [XLEN-1:0] pc, pc_inc, redirect_tgt;
  logic            ack_ok, byp_hit, buf_empty, buf_full, push_vld, pop_rdy;
  logic [CW-1:0]   count_post;
  entry_t          push_dat, head_dat;

  assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign pc_inc       = pc + XLEN'(4);
  assign ack_ok       = (state == REQ) && imem_ack_i && !redirect_i;
  assign buf_empty    = (count_o == '0);
  assign buf_full     = (count_o == FULL_CNT);

`ifdef FETCH_UNIT_BYPASS_EN
  assign byp_hit      = ack_ok && buf_empty;
  assign inst_valid_o = !buf_empty || byp_hit;
  assign inst_o       = buf_empty ? imem_data_i : head_dat.inst;
  assign inst_pc_o    = buf_empty ? pc : head_dat.pc;
`else
  assign byp_hit      = 1'b0;
  assign inst_valid_o = !buf_empty;
  assign inst_o       = head_dat.inst;
  assign inst_pc_o    = head_dat.pc;
`endif

  // A bypassed instruction consumed in its ack cycle never enters the buffer.
  assign push_vld   = ack_ok && !buf_full && !(byp_hit && inst_ready_i);
  assign pop_rdy    = !buf_empty && inst_ready_i && !redirect_i;
  assign push_dat   = '{pc: pc, inst: imem_data_i};
  assign count_post = count_o + CW'(push_vld) - CW'(pop_rdy);

  fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_buf (
    .clk      (clk_i),
    .rst      (rst_i),
    .flush    (redirect_i),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (pop_rdy),
    .head_dat (head_dat),
    .count    (count_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_i) pc <= redirect_tgt;
          imem_addr_o <= redirect_i ? redirect_tgt : pc;
          if (start_i && !buf_full) begin
            state      <= REQ;
            imem_req_o <= 1'b1;
          end
        end
        REQ: begin
          if (redirect_i) begin
            pc <= redirect_tgt;
            if (imem_ack_i) begin
              state       <= IDLE;
              imem_req_o  <= 1'b0;
              imem_addr_o <= redirect_tgt;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack_i) begin
            pc          <= pc_inc;
            imem_addr_o <= pc_inc;
            if (!(start_i && count_post < FULL_CNT)) begin
              state      <= IDLE;
              imem_req_o <= 1'b0;
            end
          end
        end
        DROP: begin
          // Address stays on the abandoned request until imem completes it.
          if (redirect_i) pc <= redirect_tgt;
          if (imem_ack_i) begin
            state       <= IDLE;
            imem_req_o  <= 1'b0;
            imem_addr_o <= redirect_i ? redirect_tgt : pc;
          end
        end
        default: begin
          state      <= IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=4, XLEN=32, RESET_PC=0); checks adapt to FETCH_UNIT_BYPASS_EN.
module tb_fetch_unit;
`ifdef FETCH_UNIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, imem_req, imem_ack, inst_valid, inst_ready, redirect;
  logic [31:0] imem_addr, imem_data, inst, inst_pc, redirect_pc, fixed_data;
  logic        use_fixed;
  logic [2:0]  count;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  assign imem_data = use_fixed ? fixed_data : (32'hA500_0000 | imem_addr);

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_data_i   (imem_data),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_ready_i  (inst_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .count_o       (count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; use_fixed = 1'b0; fixed_data = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values, then streaming fetch with an ack every cycle.
    do_reset();
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_count", count, 3'd0);
    chk("rst_valid", inst_valid, 1'b0);
    start = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1;
    tick(); #1;
    chk("a_addr0", imem_addr, 32'h0);
    chk("a_req", imem_req, 1'b1);
    tick(); #1;
    chk("a_addr4", imem_addr, 32'h4);
    chk("a_pc0", inst_pc, BYP ? 32'h4 : 32'h0);
    chk("a_valid", inst_valid, 1'b1);
    tick(); #1;
    chk("a_addr8", imem_addr, 32'h8);
    chk("a_pc4", inst_pc, BYP ? 32'h8 : 32'h4);
    chk("a_inst", inst, BYP ? 32'hA500_0008 : 32'hA500_0004);
    chk("a_count", count, BYP ? 3'd0 : 3'd1);

    // Fill with decode stalled: exactly DEPTH pushes, then idle.
    do_reset();
    start = 1'b1; imem_ack = 1'b1; inst_ready = 1'b0;
    repeat (5) tick();
    #1;
    chk("b_count4", count, 3'd4);
    chk("b_req_lo", imem_req, 1'b0);
    chk("b_head_pc", inst_pc, 32'h0);
    chk("b_head_inst", inst, 32'hA500_0000);
    tick(); #1;
    chk("b_count_hold", count, 3'd4);
    chk("b_idle", imem_req, 1'b0);

    // Redirect to 0x103 while the fetch of 0x8 is pending; ack arrives in DROP.
    do_reset();
    start = 1'b1; imem_ack = 1'b1; inst_ready = 1'b0;
    repeat (3) tick();
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    chk("c_addr8", imem_addr, 32'h8);
    tick();
    redirect = 1'b0;
    #1;
    chk("c_drop_req", imem_req, 1'b1);
    chk("c_drop_addr", imem_addr, 32'h8);
    chk("c_flushed", count, 3'd0);
    tick();
    imem_ack = 1'b1; use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("c_drop_count", count, 3'd0);
    chk("c_drop_valid", inst_valid, 1'b0);
    tick(); #1;
    chk("c_new_addr", imem_addr, 32'h100);
    chk("c_new_req", imem_req, 1'b1);

    // Redirect coincident with ack and pop while two entries are buffered.
    do_reset();
    start = 1'b1; imem_ack = 1'b1; inst_ready = 1'b0;
    repeat (3) tick();
    #1;
    chk("d_count2", count, 3'd2);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    #1;
    chk("d_count0", count, 3'd0);
    chk("d_req_lo", imem_req, 1'b0);
    tick(); #1;
    chk("d_target", imem_addr, 32'h200);
    chk("d_req_hi", imem_req, 1'b1);

    // Reset with three entries buffered beats a simultaneous redirect and ack.
    do_reset();
    start = 1'b1; imem_ack = 1'b1; inst_ready = 1'b0;
    repeat (4) tick();
    #1;
    chk("e_count3", count, 3'd3);
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    rst = 1'b0; redirect = 1'b0; start = 1'b0; imem_ack = 1'b0;
    #1;
    chk("e_count0", count, 3'd0);
    chk("e_req_lo", imem_req, 1'b0);
    chk("e_addr_rst", imem_addr, 32'h0);

    // Single fetch of 0x00000013 into an empty buffer: same-cycle only with bypass.
    do_reset();
    start = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0;
    use_fixed = 1'b1; fixed_data = 32'h0000_0013;
    tick();
    tick(); #1;
    chk("f_addr_hold", imem_addr, 32'h0);
    chk("f_req_hold", imem_req, 1'b1);
    imem_ack = 1'b1;
    #1;
    chk("f_same_valid", inst_valid, BYP);
    if (BYP) chk("f_same_inst", inst, 32'h0000_0013);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("f_next_valid", inst_valid, 1'b1);
    chk("f_next_inst", inst, 32'h0000_0013);
    chk("f_next_pc", inst_pc, 32'h0);
    chk("f_count", count, 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
